// File: rtl/gpio_led_pwm_driver.sv
// -----------------------------------------------------------------------------
// gpio_led_pwm_driver
//
// Per-channel LED waveform generator sitting between the GPIO CSR outputs and
// the LED pads. Each channel turns its CSR settings into a registered pad
// level: steady, PWM-dimmed, blinking or breathing.
//
// Every channel has the same structure:
//   prescaler -> PWM frame counter -> duty compare -> registered LED
// Duty and prescaler settings are shadowed at each frame wrap, so a CSR write
// in the middle of a frame never disturbs the frame that is running.
//
// Build option:
//   GPIO_LED_ACTIVE_LOW_EN  when defined, oGpioLed is active-low (on = 0) and
//                           the reset/disable level is 1. oGpioFrameWrap is
//                           not affected.
//
// Ports:
//   iSCLK              system clock
//   iSRST              synchronous reset, active-low
//   iGpioEn            per-channel enable; low holds that channel cleared
//   iGpioFlashMode     global mode: 0 steady, 1 PWM, 2 blink, 3 breathe
//   iGpioDutyRatio0-4  per-channel duty (on-ticks per frame)
//   iGpioIVtimer0-4    per-channel prescaler; tick period = value+1 clocks
//   oGpioLed           registered LED pad drive
//   oGpioFrameWrap     1-clock pulse after the channel frame counter wraps
// -----------------------------------------------------------------------------
module gpio_led_pwm_driver #(
    parameter int pExLedNumber    = 5,
    parameter int pExLedFlashMode = 2,
    parameter int pPWMDutyWidth   = 8,
    parameter int pIVtimerWidth   = 16
) (
    input  logic                       iSCLK,
    input  logic                       iSRST,
    input  logic [pExLedNumber-1:0]    iGpioEn,
    input  logic [pExLedFlashMode-1:0] iGpioFlashMode,
    input  logic [pPWMDutyWidth-1:0]   iGpioDutyRatio0,
    input  logic [pPWMDutyWidth-1:0]   iGpioDutyRatio1,
    input  logic [pPWMDutyWidth-1:0]   iGpioDutyRatio2,
    input  logic [pPWMDutyWidth-1:0]   iGpioDutyRatio3,
    input  logic [pPWMDutyWidth-1:0]   iGpioDutyRatio4,
    input  logic [pIVtimerWidth-1:0]   iGpioIVtimer0,
    input  logic [pIVtimerWidth-1:0]   iGpioIVtimer1,
    input  logic [pIVtimerWidth-1:0]   iGpioIVtimer2,
    input  logic [pIVtimerWidth-1:0]   iGpioIVtimer3,
    input  logic [pIVtimerWidth-1:0]   iGpioIVtimer4,
    output logic [pExLedNumber-1:0]    oGpioLed,
    output logic [pExLedNumber-1:0]    oGpioFrameWrap
);

`ifdef GPIO_LED_ACTIVE_LOW_EN
    localparam logic cLedOff = 1'b1;
`else
    localparam logic cLedOff = 1'b0;
`endif

    localparam logic [pExLedFlashMode-1:0] cModeSteady  = 0;
    localparam logic [pExLedFlashMode-1:0] cModeBlink   = 2;
    localparam logic [pExLedFlashMode-1:0] cModeBreathe = 3;

    localparam logic [pPWMDutyWidth-1:0]   cDutyOne = 1;
    localparam logic [pIVtimerWidth-1:0]   cIvOne   = 1;

    // One breathe step taken at a frame wrap. Returns {dirDownNext, rampNext}.
    // Rising: ramp+1, saturated at the duty ceiling, which also turns it down.
    // Falling: ramp-1; reaching 0 turns it back up. A duty of 0 pins ramp at 0.
    function automatic logic [pPWMDutyWidth:0] breatheStep(
        input logic                     dirDown,
        input logic [pPWMDutyWidth-1:0] ramp,
        input logic [pPWMDutyWidth-1:0] duty
    );
        logic [pPWMDutyWidth:0] rampUp;
        rampUp = {1'b0, ramp} + {1'b0, cDutyOne};
        if (!dirDown) begin
            if (rampUp >= {1'b0, duty})
                breatheStep = {1'b1, duty};
            else
                breatheStep = {1'b0, rampUp[pPWMDutyWidth-1:0]};
        end else begin
            if (ramp <= cDutyOne)
                breatheStep = '0;
            else
                breatheStep = {1'b1, ramp - cDutyOne};
        end
    endfunction

    logic [pPWMDutyWidth-1:0] dutyIn [pExLedNumber];
    logic [pIVtimerWidth-1:0] ivIn   [pExLedNumber];

    assign dutyIn[0] = iGpioDutyRatio0;
    assign dutyIn[1] = iGpioDutyRatio1;
    assign dutyIn[2] = iGpioDutyRatio2;
    assign dutyIn[3] = iGpioDutyRatio3;
    assign dutyIn[4] = iGpioDutyRatio4;
    assign ivIn[0]   = iGpioIVtimer0;
    assign ivIn[1]   = iGpioIVtimer1;
    assign ivIn[2]   = iGpioIVtimer2;
    assign ivIn[3]   = iGpioIVtimer3;
    assign ivIn[4]   = iGpioIVtimer4;

    for (genvar k = 0; k < pExLedNumber; k++) begin : gCh
        logic [pIVtimerWidth-1:0] preCnt;
        logic [pIVtimerWidth-1:0] shIVtimer;
        logic [pPWMDutyWidth-1:0] pwmCnt;
        logic [pPWMDutyWidth-1:0] shDuty;
        logic [pPWMDutyWidth-1:0] ramp;
        logic [pPWMDutyWidth-1:0] dutyEff;
        logic                     phase;
        logic                     dirDown;
        logic                     enPrev;
        logic                     ledQ;
        logic                     wrapQ;
        logic                     load;
        logic                     tick;
        logic                     wrap;
        logic                     pwmOn;
        logic                     ledOn;

        always_comb begin
            // First enabled clock only loads the shadows; counting starts after.
            load    = iGpioEn[k] & ~enPrev;
            tick    = ~load & (preCnt == shIVtimer);
            wrap    = tick & (pwmCnt == '1);
            dutyEff = (iGpioFlashMode == cModeBreathe) ? ramp : shDuty;
            pwmOn   = (pwmCnt < dutyEff);
            case (iGpioFlashMode)
                cModeSteady: ledOn = 1'b1;
                cModeBlink:  ledOn = phase & pwmOn;
                default:     ledOn = pwmOn;
            endcase
        end

        always_ff @(posedge iSCLK) begin
            if (!iSRST) begin
                preCnt    <= '0;
                shIVtimer <= '1;
                pwmCnt    <= '0;
                shDuty    <= '0;
                ramp      <= '0;
                phase     <= 1'b0;
                dirDown   <= 1'b0;
                enPrev    <= 1'b0;
                ledQ      <= cLedOff;
                wrapQ     <= 1'b0;
            end else if (!iGpioEn[k]) begin
                // Shadows are kept; they are reloaded on the next enable anyway.
                preCnt  <= '0;
                pwmCnt  <= '0;
                ramp    <= '0;
                phase   <= 1'b0;
                dirDown <= 1'b0;
                enPrev  <= 1'b0;
                ledQ    <= cLedOff;
                wrapQ   <= 1'b0;
            end else begin
                enPrev <= 1'b1;
                wrapQ  <= wrap;
                ledQ   <= (ledOn & ~load) ? ~cLedOff : cLedOff;
                if (load) begin
                    shDuty    <= dutyIn[k];
                    shIVtimer <= ivIn[k];
                    preCnt    <= '0;
                    pwmCnt    <= '0;
                end else begin
                    preCnt <= tick ? '0 : preCnt + cIvOne;
                    if (tick)
                        pwmCnt <= pwmCnt + cDutyOne;
                    if (wrap) begin
                        shDuty    <= dutyIn[k];
                        shIVtimer <= ivIn[k];
                        if (iGpioFlashMode == cModeBlink)
                            phase <= ~phase;
                        if (iGpioFlashMode == cModeBreathe)
                            {dirDown, ramp} <= breatheStep(dirDown, ramp, shDuty);
                    end
                end
            end
        end

        assign oGpioLed[k]       = ledQ;
        assign oGpioFrameWrap[k] = wrapQ;
    end

endmodule

// File: tb/tb_gpio_led_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_gpio_led_pwm_driver
//
// Directed bench for gpio_led_pwm_driver. Outputs are sampled on the falling
// clock edge; inputs are driven there too. Frame measurements start at a wrap
// pulse, so each 2^W * (IVtimer+1) sample window covers exactly one frame.
// -----------------------------------------------------------------------------
module tb_gpio_led_pwm_driver;

`ifdef GPIO_LED_ACTIVE_LOW_EN
    localparam logic cOn  = 1'b0;
    localparam logic cOff = 1'b1;
`else
    localparam logic cOn  = 1'b1;
    localparam logic cOff = 1'b0;
`endif

    logic        iSCLK = 1'b0;
    logic        iSRST = 1'b0;
    logic [4:0]  iGpioEn = '0;
    logic [1:0]  iGpioFlashMode = '0;
    logic [7:0]  iGpioDutyRatio0 = '0, iGpioDutyRatio1 = '0, iGpioDutyRatio2 = '0,
                 iGpioDutyRatio3 = '0, iGpioDutyRatio4 = '0;
    logic [15:0] iGpioIVtimer0 = '0, iGpioIVtimer1 = '0, iGpioIVtimer2 = '0,
                 iGpioIVtimer3 = '0, iGpioIVtimer4 = '0;
    logic [4:0]  oGpioLed;
    logic [4:0]  oGpioFrameWrap;

    gpio_led_pwm_driver dut (
        .iSCLK           (iSCLK),
        .iSRST           (iSRST),
        .iGpioEn         (iGpioEn),
        .iGpioFlashMode  (iGpioFlashMode),
        .iGpioDutyRatio0 (iGpioDutyRatio0),
        .iGpioDutyRatio1 (iGpioDutyRatio1),
        .iGpioDutyRatio2 (iGpioDutyRatio2),
        .iGpioDutyRatio3 (iGpioDutyRatio3),
        .iGpioDutyRatio4 (iGpioDutyRatio4),
        .iGpioIVtimer0   (iGpioIVtimer0),
        .iGpioIVtimer1   (iGpioIVtimer1),
        .iGpioIVtimer2   (iGpioIVtimer2),
        .iGpioIVtimer3   (iGpioIVtimer3),
        .iGpioIVtimer4   (iGpioIVtimer4),
        .oGpioLed        (oGpioLed),
        .oGpioFrameWrap  (oGpioFrameWrap)
    );

    always #5 iSCLK = ~iSCLK;

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp)
            nPass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic stepClk();
        @(posedge iSCLK);
        @(negedge iSCLK);
    endtask

    // Hold reset for 3 clocks, release, and pass the first enabled clock.
    task automatic applyReset();
        iSRST = 1'b0;
        repeat (3) stepClk();
        iSRST = 1'b1;
        stepClk();
    endtask

    task automatic waitWrap(input int ch, input int budget, input string tag);
        int n = 0;
        while (!oGpioFrameWrap[ch] && n < budget) begin
            stepClk();
            n++;
        end
        checkVal(tag, int'(oGpioFrameWrap[ch]), 1);
    endtask

    task automatic countFrame(input int ch, input int len, output int hi, output int wraps);
        hi    = 0;
        wraps = 0;
        for (int i = 0; i < len; i++) begin
            stepClk();
            if (oGpioLed[ch] == cOn) hi++;
            if (oGpioFrameWrap[ch]) wraps++;
        end
    endtask

    initial begin
        int hi, wr, hi2, wr2, firstWrap;
        int breatheExp [13] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 0, 0};

        // Reset with every input nonzero
        iGpioEn = 5'b11111;
        iGpioFlashMode = 2'd1;
        iGpioDutyRatio0 = 8'd10; iGpioDutyRatio1 = 8'd20; iGpioDutyRatio2 = 8'd30;
        iGpioDutyRatio3 = 8'd40; iGpioDutyRatio4 = 8'd50;
        iGpioIVtimer0 = 16'd1; iGpioIVtimer1 = 16'd2; iGpioIVtimer2 = 16'd3;
        iGpioIVtimer3 = 16'd4; iGpioIVtimer4 = 16'd5;
        iSRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checkVal("rst_led", int'(oGpioLed), int'({5{cOff}}));
            checkVal("rst_wrap", int'(oGpioFrameWrap), 0);
        end
        iSRST = 1'b1;
        stepClk();
        checkVal("rel_led", int'(oGpioLed), int'({5{cOff}}));
        checkVal("rel_wrap", int'(oGpioFrameWrap), 0);

        // PWM, ch0, every-clock tick, duty 64
        iGpioEn = 5'b00001; iGpioFlashMode = 2'd1;
        iGpioIVtimer0 = 16'd0; iGpioDutyRatio0 = 8'd64;
        applyReset();
        waitWrap(0, 600, "pwm0_wrap");
        countFrame(0, 256, hi, wr);
        checkVal("pwm0_hi", hi, 64);
        checkVal("pwm0_wraps", wr, 1);
        countFrame(0, 256, hi, wr);
        checkVal("pwm0_hi2", hi, 64);
        checkVal("pwm0_others_off", int'(oGpioLed[4:1]), int'({4{cOff}}));

        // PWM, ch1, prescale 4, duty 128 then mid-frame write to 32
        iGpioEn = 5'b00010; iGpioIVtimer1 = 16'd3; iGpioDutyRatio1 = 8'd128;
        applyReset();
        waitWrap(1, 1200, "pwm1_wrap");
        countFrame(1, 1024, hi, wr);
        checkVal("pwm1_hi", hi, 512);
        checkVal("pwm1_wraps", wr, 1);
        countFrame(1, 100, hi, wr);
        iGpioDutyRatio1 = 8'd32;
        countFrame(1, 924, hi2, wr2);
        checkVal("pwm1_midwrite_hi", hi + hi2, 512);
        checkVal("pwm1_midwrite_wraps", wr + wr2, 1);
        countFrame(1, 1024, hi, wr);
        checkVal("pwm1_newduty_hi", hi, 128);

        // Blink, ch2, duty 255
        iGpioEn = 5'b00100; iGpioFlashMode = 2'd2;
        iGpioIVtimer2 = 16'd0; iGpioDutyRatio2 = 8'd255;
        applyReset();
        waitWrap(2, 600, "blink_wrap");
        countFrame(2, 256, hi, wr);
        checkVal("blink_on_hi", hi, 255);
        countFrame(2, 256, hi, wr);
        checkVal("blink_off_hi", hi, 0);
        countFrame(2, 256, hi, wr);
        checkVal("blink_on2_hi", hi, 255);

        // Breathe, ch3, duty 4; duty dropped to 0 after the ninth frame
        iGpioEn = 5'b01000; iGpioFlashMode = 2'd3;
        iGpioIVtimer3 = 16'd0; iGpioDutyRatio3 = 8'd4;
        applyReset();
        waitWrap(3, 600, "breathe_wrap");
        for (int f = 0; f < 13; f++) begin
            if (f == 9) iGpioDutyRatio3 = 8'd0;
            countFrame(3, 256, hi, wr);
            checkVal($sformatf("breathe_f%0d", f), hi, breatheExp[f]);
        end

        // Enable drop and re-enable on ch2
        iGpioEn = 5'b00100; iGpioFlashMode = 2'd1;
        iGpioIVtimer2 = 16'd0; iGpioDutyRatio2 = 8'd200;
        applyReset();
        waitWrap(2, 600, "en_wrap");
        repeat (10) stepClk();
        checkVal("en_led_on", int'(oGpioLed[2]), int'(cOn));
        iGpioEn = 5'b00000;
        iGpioDutyRatio2 = 8'd50;
        stepClk();
        checkVal("dis_led_off", int'(oGpioLed[2]), int'(cOff));
        countFrame(2, 300, hi, wr);
        checkVal("dis_hi", hi, 0);
        checkVal("dis_wraps", wr, 0);
        iGpioEn = 5'b00100;
        stepClk();
        checkVal("reen_load_off", int'(oGpioLed[2]), int'(cOff));
        hi = 0;
        firstWrap = 0;
        for (int i = 1; i <= 256; i++) begin
            stepClk();
            if (oGpioLed[2] == cOn) hi++;
            if (oGpioFrameWrap[2] && firstWrap == 0) firstWrap = i;
        end
        checkVal("reen_hi", hi, 50);
        checkVal("reen_first_wrap", firstWrap, 256);

        // Mode change to steady takes effect on the next clock
        iGpioFlashMode = 2'd0;
        stepClk();
        checkVal("steady_led", int'(oGpioLed), int'({cOff, cOff, cOn, cOff, cOff}));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
